jtopl_slot_regs: RTL and testbench

CPU-facing OPL2 register file that feeds per-slot envelope parameters to the envelope generator. It accepts the chip's two-port (address/data) write protocol and stores operator and channel registers for 18 slots. It walks the slots in time-multiplexed order, one per `cenop`, presenting each slot's keyon, rates, sustain, frequency and level fields. Each field is aligned to the pipeline stage at which the envelope generator consumes it.

---
 rtl/jtopl_pkg.sv | 70 +++++++
 rtl/jtopl_sh.sv | 26 ++
 rtl/jtopl_slot_cnt.sv | 21 ++
 rtl/jtopl_slot_regs.sv | 154 +++++++++++++++
 tb/tb_jtopl_slot_regs.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtopl_pkg.sv
// Shared OPL2 slot-register definitions: register bases, field layouts and
// operator-offset / slot / channel mapping helpers.
package jtopl_pkg;

    localparam int SLOTS    = 18;
    localparam int CHANNELS = 9;

    // Operator register groups, selected by address bits [7:5]
    localparam logic [2:0] OP_AM = 3'd1;    // 0x20: amsen / en_sus / ksr
    localparam logic [2:0] OP_TL = 3'd2;    // 0x40: ksl / tl
    localparam logic [2:0] OP_AR = 3'd3;    // 0x60: arate / drate
    localparam logic [2:0] OP_SL = 3'd4;    // 0x80: sl / rrate

    // Channel register groups, selected by address bits [7:4]
    localparam logic [3:0] CH_FNUM = 4'hA;
    localparam logic [3:0] CH_BLK  = 4'hB;

    localparam logic [7:0] REG_NTS = 8'h08;

    typedef struct packed {
        logic       amsen;
        logic       en_sus;
        logic       ksr;
        logic [1:0] ksl;
        logic [5:0] tl;
        logic [3:0] arate;
        logic [3:0] drate;
        logic [3:0] sl;
        logic [3:0] rrate;
    } op_regs_t;

    typedef struct packed {
        logic       keyon;
        logic [2:0] block;
        logic [9:0] fnum;
    } ch_regs_t;

    // Offsets 6, 7, 0xE, 0xF and everything from 0x16 up have no operator
    function automatic logic op_valid(input logic [4:0] o);
        return (o[2:0] < 3'd6) && (o[4:3] != 2'd3);
    endfunction

    function automatic logic [4:0] op2slot(input logic [4:0] o);
        logic [4:0] base;
        case (o[4:3])
            2'd1:    base = 5'd6;
            2'd2:    base = 5'd12;
            default: base = 5'd0;
        endcase
        return base + {2'b00, o[2:0]};
    endfunction

    function automatic logic [3:0] slot2ch(input logic [4:0] s);
        logic [3:0] ch;
        case (s)
            5'd0,  5'd3:  ch = 4'd0;
            5'd1,  5'd4:  ch = 4'd1;
            5'd2,  5'd5:  ch = 4'd2;
            5'd6,  5'd9:  ch = 4'd3;
            5'd7,  5'd10: ch = 4'd4;
            5'd8,  5'd11: ch = 4'd5;
            5'd12, 5'd15: ch = 4'd6;
            5'd13, 5'd16: ch = 4'd7;
            5'd14, 5'd17: ch = 4'd8;
            default:      ch = 4'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/jtopl_sh.sv
// Clock-enabled shift register used to align fields to later pipeline stages.
module jtopl_sh #(
    parameter int W      = 1,
    parameter int STAGES = 1
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] drop
);

    logic [W-1:0] bits [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) bits[i] <= '0;
        end else if (cen) begin
            bits[0] <= din;
            for (int i = 1; i < STAGES; i++) bits[i] <= bits[i-1];
        end
    end

    assign drop = bits[STAGES-1];

endmodule

// File: rtl/jtopl_slot_cnt.sv
// Operator slot counter: walks 0..SLOTS-1 once per cenop and flags slot 0.
module jtopl_slot_cnt (
    input  logic       rst,
    input  logic       clk,
    input  logic       cenop,
    output logic [4:0] slot,
    output logic       zero
);
    import jtopl_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= 5'd0;
        end else if (cenop) begin
            slot <= (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
        end
    end

    assign zero = (slot == 5'd0);

endmodule

// File: rtl/jtopl_slot_regs.sv
// OPL2 operator/channel register file feeding per-slot envelope parameters.
// Optional CPU readback of stored registers: define JTOPL_SLOT_READBACK_EN.
module jtopl_slot_regs (
    input  logic       rst,
    input  logic       clk,
    input  logic       cenop,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       zero,
    output logic [4:0] slot,
    output logic       keyon_I,
    output logic       en_sus_I,
    output logic [3:0] arate_I,
    output logic [3:0] drate_I,
    output logic [3:0] rrate_I,
    output logic [3:0] sl_I,
    output logic [9:0] fnum_I,
    output logic [2:0] block_I,
    output logic [3:0] keycode_II,
    output logic       ksr_II,
    output logic       amsen_IV,
    output logic [5:0] tl_IV,
    output logic [1:0] ksl_IV
);
    import jtopl_pkg::*;

    logic [7:0] addr;
    logic       nts;
    op_regs_t   op_mem [SLOTS];
    ch_regs_t   ch_mem [CHANNELS];

    logic       op_hit;
    logic [4:0] op_slot;
    logic       ch_hit;
    logic [3:0] ch_idx;

    assign op_hit  = (addr[7:5] >= OP_AM) && (addr[7:5] <= OP_SL) && op_valid(addr[4:0]);
    assign op_slot = op2slot(addr[4:0]);
    assign ch_idx  = addr[3:0];
    assign ch_hit  = ((addr[7:4] == CH_FNUM) || (addr[7:4] == CH_BLK)) && (ch_idx < 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= 8'd0;
            nts  <= 1'b0;
            for (int i = 0; i < SLOTS; i++)    op_mem[i] <= '0;
            for (int i = 0; i < CHANNELS; i++) ch_mem[i] <= '0;
        end else if (wr && !a0) begin
            addr <= din;
        end else if (wr && a0) begin
            if (addr == REG_NTS) nts <= din[6];
            if (op_hit) begin
                case (addr[7:5])
                    OP_AM: begin
                        op_mem[op_slot].amsen  <= din[7];
                        op_mem[op_slot].en_sus <= din[5];
                        op_mem[op_slot].ksr    <= din[4];
                    end
                    OP_TL: begin
                        op_mem[op_slot].ksl <= din[7:6];
                        op_mem[op_slot].tl  <= din[5:0];
                    end
                    OP_AR: begin
                        op_mem[op_slot].arate <= din[7:4];
                        op_mem[op_slot].drate <= din[3:0];
                    end
                    OP_SL: begin
                        op_mem[op_slot].sl    <= din[7:4];
                        op_mem[op_slot].rrate <= din[3:0];
                    end
                    default: ;
                endcase
            end
            if (ch_hit) begin
                if (addr[7:4] == CH_FNUM) begin
                    ch_mem[ch_idx].fnum[7:0] <= din;
                end else begin
                    ch_mem[ch_idx].keyon     <= din[5];
                    ch_mem[ch_idx].block     <= din[4:2];
                    ch_mem[ch_idx].fnum[9:8] <= din[1:0];
                end
            end
        end
    end

    jtopl_slot_cnt u_cnt (
        .rst   (rst),
        .clk   (clk),
        .cenop (cenop),
        .slot  (slot),
        .zero  (zero)
    );

    // Stage I reads straight from the arrays, so a write that lands on the
    // same edge the slot is consumed is only seen on the slot's next visit.
    op_regs_t   op_cur;
    ch_regs_t   ch_cur;
    logic [3:0] keycode_I;

    assign op_cur    = op_mem[slot];
    assign ch_cur    = ch_mem[slot2ch(slot)];
    assign keyon_I   = ch_cur.keyon;
    assign block_I   = ch_cur.block;
    assign fnum_I    = ch_cur.fnum;
    assign en_sus_I  = op_cur.en_sus;
    assign arate_I   = op_cur.arate;
    assign drate_I   = op_cur.drate;
    assign rrate_I   = op_cur.rrate;
    assign sl_I      = op_cur.sl;
    assign keycode_I = {ch_cur.block, nts ? ch_cur.fnum[8] : ch_cur.fnum[9]};

    jtopl_sh #(.W(5), .STAGES(1)) u_sh_ii (
        .rst  (rst),
        .clk  (clk),
        .cen  (cenop),
        .din  ({keycode_I, op_cur.ksr}),
        .drop ({keycode_II, ksr_II})
    );

    jtopl_sh #(.W(9), .STAGES(3)) u_sh_iv (
        .rst  (rst),
        .clk  (clk),
        .cen  (cenop),
        .din  ({op_cur.amsen, op_cur.tl, op_cur.ksl}),
        .drop ({amsen_IV, tl_IV, ksl_IV})
    );

`ifdef JTOPL_SLOT_READBACK_EN
    always_comb begin
        dout = 8'd0;
        if (op_hit) begin
            case (addr[7:5])
                OP_AM:   dout = {op_mem[op_slot].amsen, 1'b0, op_mem[op_slot].en_sus,
                                 op_mem[op_slot].ksr, 4'd0};
                OP_TL:   dout = {op_mem[op_slot].ksl, op_mem[op_slot].tl};
                OP_AR:   dout = {op_mem[op_slot].arate, op_mem[op_slot].drate};
                OP_SL:   dout = {op_mem[op_slot].sl, op_mem[op_slot].rrate};
                default: dout = 8'd0;
            endcase
        end else if (ch_hit) begin
            if (addr[7:4] == CH_FNUM) dout = ch_mem[ch_idx].fnum[7:0];
            else dout = {2'b00, ch_mem[ch_idx].keyon, ch_mem[ch_idx].block,
                         ch_mem[ch_idx].fnum[9:8]};
        end else if (addr == REG_NTS) begin
            dout = {1'b0, nts, 6'd0};
        end
    end
`else
    assign dout = 8'd0;
`endif

endmodule

// File: tb/tb_jtopl_slot_regs.sv
// Self-checking bench for jtopl_slot_regs: byte-level register model plus
// directed register-map scenarios and randomized CPU/cenop traffic.
module tb_jtopl_slot_regs;

    logic       rst = 1'b0, clk = 1'b0, cenop = 1'b0, wr = 1'b0, a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       zero, keyon_I, en_sus_I, ksr_II, amsen_IV;
    logic [4:0] slot;
    logic [3:0] arate_I, drate_I, rrate_I, sl_I, keycode_II;
    logic [9:0] fnum_I;
    logic [2:0] block_I;
    logic [5:0] tl_IV;
    logic [1:0] ksl_IV;

    jtopl_slot_regs dut (
        .rst(rst), .clk(clk), .cenop(cenop), .wr(wr), .a0(a0), .din(din), .dout(dout),
        .zero(zero), .slot(slot), .keyon_I(keyon_I), .en_sus_I(en_sus_I),
        .arate_I(arate_I), .drate_I(drate_I), .rrate_I(rrate_I), .sl_I(sl_I),
        .fnum_I(fnum_I), .block_I(block_I), .keycode_II(keycode_II), .ksr_II(ksr_II),
        .amsen_IV(amsen_IV), .tl_IV(tl_IV), .ksl_IV(ksl_IV)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: raw register bytes ----------------
    typedef struct packed {
        logic       keyon, en_sus;
        logic [3:0] arate, drate, rrate, sl;
        logic [9:0] fnum;
        logic [2:0] block;
        logic [3:0] keycode;
        logic       ksr, amsen;
        logic [5:0] tl;
        logic [1:0] ksl;
    } exp_t;

    logic [7:0] mem [256];
    logic [7:0] maddr;
    int         mslot;
    exp_t       ii, iv [3];
    exp_t       cur_m, ce;

    function automatic bit mapped(input logic [7:0] a);
        int ai = int'(a);
        if (ai == 8) return 1;
        if (ai >= 'h20 && ai < 'hA0) return ((ai % 32) % 8) < 6 && ((ai % 32) / 8) < 3;
        if ((ai / 16) == 10 || (ai / 16) == 11) return (ai % 16) < 9;
        return 0;
    endfunction

    function automatic logic [7:0] mask(input logic [7:0] a);
        int ai = int'(a);
        if (ai == 8) return 8'h40;
        if (ai / 32 == 1) return 8'hB0;
        if (ai / 16 == 11) return 8'h3F;
        return 8'hFF;
    endfunction

    function automatic exp_t stage_i(input int s);
        exp_t e;
        int grp = s / 6, idx = s % 6;
        int o = grp * 8 + idx, ch = grp * 3 + idx % 3;
        logic [7:0] r2, r4, r6, r8, ra, rb;
        r2 = mem[32 + o]; r4 = mem[64 + o]; r6 = mem[96 + o]; r8 = mem[128 + o];
        ra = mem[160 + ch]; rb = mem[176 + ch];
        e = '0;
        e.amsen = r2[7]; e.en_sus = r2[5]; e.ksr = r2[4];
        e.ksl = r4[7:6]; e.tl = r4[5:0];
        e.arate = r6[7:4]; e.drate = r6[3:0];
        e.sl = r8[7:4]; e.rrate = r8[3:0];
        e.keyon = rb[5]; e.block = rb[4:2]; e.fnum = {rb[1:0], ra};
        e.keycode = {e.block, mem[8][6] ? e.fnum[8] : e.fnum[9]};
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'd0;
            maddr = 8'd0; mslot = 0; ii = '0;
            for (int i = 0; i < 3; i++) iv[i] = '0;
        end else begin
            if (cenop) begin
                cur_m = stage_i(mslot);
                iv[2] = iv[1]; iv[1] = iv[0]; iv[0] = cur_m; ii = cur_m;
                mslot = (mslot + 1) % 18;
            end
            if (wr) begin
                if (!a0) maddr = din;
                else if (mapped(maddr)) mem[maddr] = din & mask(maddr);
            end
        end
    end

    // Per-cycle comparison, sampled well after the active edge
    always @(posedge clk) begin
        #2;
        if (check_en) begin
            ce = stage_i(mslot);
            chk("slot", slot, mslot);
            chk("zero", zero, mslot == 0);
            chk("keyon_I", keyon_I, ce.keyon);
            chk("en_sus_I", en_sus_I, ce.en_sus);
            chk("arate_I", arate_I, ce.arate);
            chk("drate_I", drate_I, ce.drate);
            chk("rrate_I", rrate_I, ce.rrate);
            chk("sl_I", sl_I, ce.sl);
            chk("fnum_I", fnum_I, ce.fnum);
            chk("block_I", block_I, ce.block);
            chk("keycode_II", keycode_II, ii.keycode);
            chk("ksr_II", ksr_II, ii.ksr);
            chk("amsen_IV", amsen_IV, iv[2].amsen);
            chk("tl_IV", tl_IV, iv[2].tl);
            chk("ksl_IV", ksl_IV, iv[2].ksl);
`ifdef JTOPL_SLOT_READBACK_EN
            chk("dout", dout, mapped(maddr) ? mem[maddr] : 8'd0);
`else
            chk("dout", dout, 8'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); wr = 1; a0 = 0; din = a;
        @(negedge clk); a0 = 1; din = d;
        @(negedge clk); wr = 0; a0 = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); cenop = 1; end
        @(negedge clk); cenop = 0;
    endtask

    task automatic goto_slot(input int t);
        int n = (t + 18 - mslot) % 18;
        if (n > 0) step(n);
        chk("goto_slot", slot, t);
    endtask

    function automatic logic [7:0] pick_addr();
        int k = $urandom_range(0, 6);
        if (k < 4) return 8'(32 * (k + 1) + $urandom_range(0, 23));
        if (k == 4) return 8'('hA0 + $urandom_range(0, 9));
        if (k == 5) return 8'('hB0 + $urandom_range(0, 9));
        return ($urandom % 2) ? 8'h08 : 8'($urandom);
    endfunction

    initial begin
        #1 rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        check_en = 1;

        // Reset state
        chk("rst_zero", zero, 1); chk("rst_slot", slot, 0);
        chk("rst_arate", arate_I, 0); chk("rst_keyon", keyon_I, 0);
        chk("rst_fnum", fnum_I, 0); chk("rst_keycode", keycode_II, 0);
        chk("rst_tl", tl_IV, 0); chk("rst_dout", dout, 0);

        // Operator register mapping on slot 0
        write_reg(8'h60, 8'hF3);
        write_reg(8'h80, 8'h2A);
        chk("map_arate", arate_I, 4'hF); chk("map_drate", drate_I, 4'h3);
        chk("map_sl", sl_I, 4'h2); chk("map_rrate", rrate_I, 4'hA);
        step(1);
        chk("slot1_arate", arate_I, 0); chk("slot1_sl", sl_I, 0);

        // Channel 4 lives on slots 7 and 10
        write_reg(8'hA4, 8'h55);
        write_reg(8'hB4, 8'h3E);
        goto_slot(4);
        chk("ch1_keyon", keyon_I, 0);
        goto_slot(7);
        chk("ch4_keyon", keyon_I, 1); chk("ch4_block", block_I, 7); chk("ch4_fnum", fnum_I, 10'h255);
        step(1);
        chk("keycode_nts0", keycode_II, 4'hF);
        goto_slot(10);
        chk("ch4b_keyon", keyon_I, 1); chk("ch4b_fnum", fnum_I, 10'h255);
        write_reg(8'h08, 8'h40);
        goto_slot(7);
        step(1);
        chk("keycode_nts1", keycode_II, 4'hE);

        // Stage IV alignment on slot 14
        write_reg(8'h52, 8'hC7);
        goto_slot(14);
        step(3);
        chk("tl_IV14", tl_IV, 7); chk("ksl_IV14", ksl_IV, 3);

        // Unmapped offset 6 must not reach any slot
        write_reg(8'h26, 8'hFF);
        for (int i = 0; i < 18; i++) begin
            chk("unmapped_en_sus", en_sus_I, 0);
            step(1);
        end

        // Write to slot 5 on the edge that consumes slot 5
        goto_slot(5);
        @(negedge clk); wr = 1; a0 = 0; din = 8'h85;
        @(negedge clk); a0 = 1; din = 8'h47; cenop = 1;
        chk("coll_old_sl", sl_I, 0);
        @(negedge clk); wr = 0; a0 = 0; cenop = 0;
        chk("coll_slot", slot, 6);
        step(17);
        chk("coll_new_slot", slot, 5); chk("coll_new_sl", sl_I, 4); chk("coll_new_rr", rrate_I, 7);

        // Readback
        write_reg(8'h40, 8'h81);
        @(negedge clk); wr = 1; a0 = 0; din = 8'h40;
        @(negedge clk); wr = 0;
`ifdef JTOPL_SLOT_READBACK_EN
        chk("readback", dout, 8'h81);
`else
        chk("readback", dout, 8'h00);
`endif

        // Randomized traffic
        repeat (2000) begin
            @(negedge clk);
            cenop = ($urandom % 4) != 0;
            wr = $urandom % 2;
            a0 = $urandom % 2;
            din = a0 ? 8'($urandom) : pick_addr();
        end
        @(negedge clk); wr = 0; a0 = 0; cenop = 0;

        // Reset mid-frame clears keyons and restarts at slot 0
        write_reg(8'hB0, 8'h20);
        step(5);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("mid_rst_slot", slot, 0); chk("mid_rst_zero", zero, 1);
        for (int i = 0; i < 18; i++) begin
            chk("mid_rst_keyon", keyon_I, 0);
            step(1);
        end

        @(negedge clk);
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
